// File: rtl/kv_mem_pkg.sv
// kv_mem_arbiter shared types: FSM states and line width helper.
package kv_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DELIVER
  } state_t;

  function automatic int line_width(
    input int dw,
    input int ls
  );
    return dw * ls;
  endfunction

endpackage

// File: rtl/kv_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr.
module kv_rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  always_comb begin
    int  idx;
    logic found;
    gnt   = '0;
    idx   = 0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/kv_mem_arbiter.sv
// Line-fetch / write-back arbiter in front of a single-outstanding
// line memory port.
module kv_mem_arbiter
  import kv_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_SIZE  = 4,
  parameter int REQ_NUM    = 2,
  localparam int LW = line_width(DATA_WIDTH, LINE_SIZE)
) (
  input  logic                          i_clk,
  input  logic                          i_rstn,
  input  logic [REQ_NUM-1:0]            i_rd_valid,
  output logic [REQ_NUM-1:0]            o_rd_ready,
  input  logic [REQ_NUM*ADDR_WIDTH-1:0] i_rd_addr,
  output logic [REQ_NUM-1:0]            o_rd_valid,
  input  logic [REQ_NUM-1:0]            i_rd_ready,
  output logic [LW-1:0]                 o_rd_data,
  input  logic                          i_wr_valid,
  output logic                          o_wr_ready,
  input  logic [ADDR_WIDTH-1:0]         i_wr_addr,
  input  logic [LW-1:0]                 i_wr_data,
  output logic                          o_mem_valid,
  input  logic                          i_mem_ready,
  output logic                          o_mem_we,
  output logic [ADDR_WIDTH-1:0]         o_mem_addr,
  output logic [LW-1:0]                 o_mem_wdata,
  input  logic                          i_mem_rvalid,
  output logic                          o_mem_rready,
  input  logic [LW-1:0]                 i_mem_rdata
);

  localparam int PW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  state_t state, state_nx;

  logic [REQ_NUM-1:0]    r_grant;
  logic [REQ_NUM-1:0]    rr_gnt;
  logic                  r_is_wr;
  logic                  r_last_wr;
  logic [PW-1:0]         r_rr_ptr;
  logic [PW-1:0]         ptr_nx;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] rd_addr_sel;
  logic [LW-1:0]         r_wdata;
  logic [LW-1:0]         r_rdata;
  logic                  wr_pick;
  logic                  rd_pick;
  logic                  deliver_done;

  kv_rr_arbiter #(
    .N  (REQ_NUM),
    .PW (PW)
  ) u_rr (
    .req (i_rd_valid),
    .ptr (r_rr_ptr),
    .gnt (rr_gnt)
  );

  always_comb begin
    rd_addr_sel = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (rr_gnt[i]) begin
        rd_addr_sel = i_rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  always_comb begin
    ptr_nx = r_rr_ptr;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (r_grant[i]) begin
        ptr_nx = PW'((i + 1) % REQ_NUM);
      end
    end
  end

  assign deliver_done = |(i_rd_ready & r_grant);

  always_comb begin
    state_nx     = state;
    wr_pick      = 1'b0;
    rd_pick      = 1'b0;
    o_wr_ready   = 1'b0;
    o_rd_ready   = '0;
    o_mem_valid  = 1'b0;
    o_mem_rready = 1'b0;
    o_rd_valid   = '0;
    unique case (state)
      S_IDLE: begin
        // a write just went out: pending reads take this slot
        wr_pick    = i_wr_valid && !(r_last_wr && |i_rd_valid);
        rd_pick    = !wr_pick && |i_rd_valid;
        o_wr_ready = wr_pick;
        o_rd_ready = rd_pick ? rr_gnt : '0;
        if (wr_pick || rd_pick) state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        o_mem_valid = 1'b1;
        if (i_mem_ready) state_nx = r_is_wr ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        o_mem_rready = 1'b1;
        if (i_mem_rvalid) state_nx = S_DELIVER;
      end
      S_DELIVER: begin
        o_rd_valid = r_grant;
        if (deliver_done) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= S_IDLE;
      r_grant   <= '0;
      r_is_wr   <= 1'b0;
      r_last_wr <= 1'b0;
      r_rr_ptr  <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && (wr_pick || rd_pick)) begin
        r_is_wr   <= wr_pick;
        r_last_wr <= wr_pick;
        r_grant   <= wr_pick ? '0 : rr_gnt;
        r_addr    <= wr_pick ? i_wr_addr : rd_addr_sel;
        r_wdata   <= wr_pick ? i_wr_data : '0;
      end
      if (state == S_WAIT && i_mem_rvalid) begin
        r_rdata <= i_mem_rdata;
      end
      if (state == S_DELIVER && deliver_done) begin
        r_rr_ptr <= ptr_nx;
      end
    end
  end

  assign o_mem_addr  = r_addr;
  assign o_mem_we    = r_is_wr;
  assign o_mem_wdata = r_wdata;
  assign o_rd_data   = r_rdata;

endmodule
